// File: rtl/ipml_prefetch_fifo_sync_v2.sv
// ipml_prefetch_fifo_sync_v2
// Single-clock first-word-fall-through FIFO: inferred simple-dual-port RAM
// with an unregistered read port, followed by a 2-entry output register stage.
// Provides an occupancy count, almost-full/almost-empty flags and a
// synchronous flush.
// Optional macro PREFETCH_FIFO_ERR_FLAG_EN adds sticky wr_ovf / rd_udf flags.
module ipml_prefetch_fifo_sync_v2 #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 10,
  parameter int AFULL_TH  = (1 << DEPTH_W) - 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DEPTH_W+1:0] level,
  output logic              almost_full,
  output logic              almost_empty
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
  ,
  output logic              wr_ovf,
  output logic              rd_udf
`endif
);

  localparam int RAM_WORDS = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0]   RAM_FULL  = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W+1:0] AFULL_LV  = (DEPTH_W+2)'(AFULL_TH);
  localparam logic [DEPTH_W+1:0] AEMPTY_LV = (DEPTH_W+2)'(AEMPTY_TH);

  // Storage; content survives reset and flush (pointers make it invisible).
  logic [DATA_W-1:0] mem [RAM_WORDS];

  logic [DEPTH_W-1:0]  wr_ptr_reg;
  logic [DEPTH_W-1:0]  rd_ptr_reg;
  logic [DEPTH_W-1:0]  rd_addr_reg;   // address of the word currently in flight
  logic [DEPTH_W:0]    ram_cnt_reg;
  logic                inflight_reg;
  logic [DATA_W-1:0]   out0_reg;      // head of the output stage
  logic [DATA_W-1:0]   out1_reg;
  logic [1:0]          out_cnt_reg;
  logic [DEPTH_W+1:0]  level_reg;
  logic                afull_reg;
  logic                aempty_reg;

  logic                accept_wr;
  logic                pop;
  logic                pre;
  logic [2:0]          stage_need;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DEPTH_W:0]    ram_cnt_next;
  logic [DEPTH_W+1:0]  level_next;
  logic [1:0]          cnt_after_pop;
  logic [1:0]          out_cnt_next;
  logic [DATA_W-1:0]   out0_next;
  logic [DATA_W-1:0]   out1_next;

  assign wr_ready     = (ram_cnt_reg != RAM_FULL);
  assign rd_valid     = (out_cnt_reg != 2'd0);
  assign rd_data      = out0_reg;
  assign level        = level_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;

  assign accept_wr = wr_valid & wr_ready;
  assign pop       = rd_valid & rd_ready;

  // Issue a RAM read only if the output stage can absorb it next cycle,
  // counting the word already in flight and the slot freed by this pop.
  assign stage_need = {1'b0, out_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign pre        = (ram_cnt_reg != '0) & (stage_need < 3'd2);

  assign ram_rdata    = mem[rd_addr_reg];
  assign ram_cnt_next = ram_cnt_reg + (DEPTH_W+1)'(accept_wr) - (DEPTH_W+1)'(pre);
  assign level_next   = level_reg + (DEPTH_W+2)'(accept_wr) - (DEPTH_W+2)'(pop);

  // Output stage next state: shift on pop, then land the in-flight word in
  // the first free slot.
  always_comb begin
    out0_next     = out0_reg;
    out1_next     = out1_reg;
    cnt_after_pop = out_cnt_reg - {1'b0, pop};
    if (pop) begin
      out0_next = out1_reg;
    end
    if (inflight_reg) begin
      if (cnt_after_pop == 2'd0) begin
        out0_next = ram_rdata;
      end else begin
        out1_next = ram_rdata;
      end
    end
    out_cnt_next = cnt_after_pop + {1'b0, inflight_reg};
  end

  // RAM write port; a flush cycle discards the write.
  always_ff @(posedge clk) begin
    if (accept_wr && !flush) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, counters, output stage and threshold flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_addr_reg  <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      out0_reg     <= '0;
      out1_reg     <= '0;
      out_cnt_reg  <= 2'd0;
      level_reg    <= '0;
      afull_reg    <= 1'b0;
      aempty_reg   <= 1'b1;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_addr_reg  <= '0;
      ram_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      out0_reg     <= '0;
      out1_reg     <= '0;
      out_cnt_reg  <= 2'd0;
      level_reg    <= '0;
      afull_reg    <= 1'b0;
      aempty_reg   <= 1'b1;
    end else begin
      if (accept_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pre) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_addr_reg <= rd_ptr_reg;
      end
      ram_cnt_reg  <= ram_cnt_next;
      inflight_reg <= pre;
      out0_reg     <= out0_next;
      out1_reg     <= out1_next;
      out_cnt_reg  <= out_cnt_next;
      level_reg    <= level_next;
      afull_reg    <= (level_next >= AFULL_LV);
      aempty_reg   <= (level_next <= AEMPTY_LV);
    end
  end

`ifdef PREFETCH_FIFO_ERR_FLAG_EN
  // Sticky overflow/underflow indicators, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else if (flush) begin
      wr_ovf <= 1'b0;
      rd_udf <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) begin
        wr_ovf <= 1'b1;
      end
      if (rd_ready && !rd_valid) begin
        rd_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ipml_prefetch_fifo_sync_v2.sv
// Testbench for ipml_prefetch_fifo_sync_v2 (DEPTH_W = 4, DATA_W = 32).
// A queue-based reference model tracks contents and accept times; outputs are
// derived from it every cycle, plus directed literal checks.
module tb_ipml_prefetch_fifo_sync_v2;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int RAMW = 16;
  localparam int AFT  = 12;
  localparam int AET  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [AW+1:0] level;
  logic          almost_full;
  logic          almost_empty;
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
  logic          wr_ovf;
  logic          rd_udf;
`endif

  ipml_prefetch_fifo_sync_v2 #(
    .DATA_W   (DW),
    .DEPTH_W  (AW),
    .AFULL_TH (AFT),
    .AEMPTY_TH(AET)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
    ,
    .wr_ovf      (wr_ovf),
    .rd_udf      (rd_udf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: words held, the edge index at which each was accepted.
  logic [DW-1:0] mq[$];
  int            tq[$];
  int            cyc = 0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            mv;
  bit            mw;
  logic [DW-1:0] popped;

  // Head is visible two edges after it was accepted.
  function automatic bit m_valid();
    return (mq.size() > 0) && (tq[0] <= cyc - 2);
  endfunction

  // Up to two words that have sat in the RAM for at least one edge have been
  // moved towards the output; the rest still occupy RAM.
  function automatic int m_pref();
    int n = 0;
    foreach (tq[i]) if (tq[i] <= cyc - 1) n++;
    return (n > 2) ? 2 : n;
  endfunction

  function automatic bit m_wr_ready();
    return (mq.size() - m_pref()) != RAMW;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        tq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        mv = m_valid();
        mw = m_wr_ready();
        cyc++;
        if (flush) begin
          mq.delete();
          tq.delete();
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end else begin
          if (wr_valid && !mw) m_ovf = 1'b1;
          if (rd_ready && !mv) m_udf = 1'b1;
          if (mv && rd_ready) begin
            popped = mq.pop_front();
            void'(tq.pop_front());
            $display("pop  data=0x%08h level_after=%0d", popped, mq.size() + ((wr_valid && mw) ? 1 : 0));
          end
          if (wr_valid && mw) begin
            mq.push_back(wr_data);
            tq.push_back(cyc);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("level", 32'(level), 32'(mq.size()));
        check("rd_valid", 32'(rd_valid), 32'(m_valid()));
        check("wr_ready", 32'(wr_ready), 32'(m_wr_ready()));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
        check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AET));
        if (m_valid()) check("rd_data", rd_data, mq[0]);
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
        check("wr_ovf", 32'(wr_ovf), 32'(m_ovf));
        check("rd_udf", 32'(rd_udf), 32'(m_udf));
`endif
      end
    end
  end

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  int acc;
  int guard;
  bit rwv;
  bit rrr;

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_almost_empty", 32'(almost_empty), 32'd1);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    $display("phase single_word");

    // Single word: accepted at edge 0, visible after edge 2, popped at edge 3
    step(1, 32'hA5A5_0001, 0, 0);
    check("sw_level_e0", 32'(level), 32'd1);
    check("sw_valid_e0", 32'(rd_valid), 32'd0);
    step(0, 0, 0, 0);
    check("sw_valid_e1", 32'(rd_valid), 32'd0);
    step(0, 0, 0, 0);
    check("sw_valid_e2", 32'(rd_valid), 32'd1);
    check("sw_data_e2", rd_data, 32'hA5A5_0001);
    step(0, 0, 1, 0);
    check("sw_level_e3", 32'(level), 32'd0);
    check("sw_valid_e3", 32'(rd_valid), 32'd0);
    check("sw_aempty_e3", 32'(almost_empty), 32'd1);
    $display("phase fill");

    // Fill: 20 writes, 18 accepted
    for (int i = 0; i < 20; i++) step(1, 32'(i), 0, 0);
    check("fill_level", 32'(level), 32'd18);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_afull", 32'(almost_full), 32'd1);
`ifdef PREFETCH_FIFO_ERR_FLAG_EN
    check("fill_wr_ovf", 32'(wr_ovf), 32'd1);
`endif
    $display("phase drain");

    // Drain: 0..17 on consecutive cycles
    for (int i = 0; i < 18; i++) begin
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", rd_data, 32'(i));
      step(0, 0, 1, 0);
      if (i == 0) check("drain_wr_ready_after_pop", 32'(wr_ready), 32'd1);
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_valid_end", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
    $display("phase streaming");

    // Streaming across pointer wrap
    for (int i = 0; i < 50; i++) step(1, 32'h0000_1000 + 32'(i), 1, 0);
    repeat (6) step(0, 0, 1, 0);
    check("stream_level_end", 32'(level), 32'd0);
    $display("phase random");

    // Random backpressure until 1000 words accepted
    acc = 0;
    guard = 0;
    while (acc < 1000 && guard < 20000) begin
      rwv = 1'($urandom_range(0, 1));
      rrr = 1'($urandom_range(0, 1));
      if (rwv && wr_ready) acc++;
      step(rwv, $urandom, rrr, 0);
      guard++;
    end
    check("random_accept_count", 32'(acc), 32'd1000);
    repeat (25) step(0, 0, 1, 0);
    check("random_level_end", 32'(level), 32'd0);
    $display("phase flush");

    // Flush with a read in flight
    for (int i = 0; i < 8; i++) step(1, 32'h0000_0F00 + 32'(i), 0, 0);
    step(0, 0, 1, 0);
    check("pre_flush_level", 32'(level), 32'd7);
    step(1, 32'h0000_DEAD, 1, 1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    check("flush_wr_ready", 32'(wr_ready), 32'd1);
    check("flush_rd_data", rd_data, 32'd0);
    check("flush_afull", 32'(almost_full), 32'd0);
    check("flush_aempty", 32'(almost_empty), 32'd1);
    step(1, 32'h0000_0055, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("post_flush_valid", 32'(rd_valid), 32'd1);
    check("post_flush_data", rd_data, 32'h0000_0055);
    step(0, 0, 1, 0);
    check("post_flush_level", 32'(level), 32'd0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
